// File: rtl/imem_arbiter.sv
// Single-port instruction memory arbiter between fetch and a loader/debug master, with a burst limiter.
// Optional address checking is enabled by defining IMEM_ARB_CHECK_EN.
module imem_arbiter #(
  parameter int IMEM_DEPTH = 256,
  parameter int MAX_BURST  = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          f_req,
  input  logic [31:0]                   f_addr,
  output logic                          f_gnt,
  output logic                          f_rvalid,
  output logic [31:0]                   f_rdata,
  output logic                          f_err,
  input  logic                          l_req,
  input  logic                          l_we,
  input  logic [31:0]                   l_addr,
  input  logic [31:0]                   l_wdata,
  input  logic                          l_lock,
  output logic                          l_gnt,
  output logic                          l_rvalid,
  output logic [31:0]                   l_rdata,
  output logic                          l_err,
  output logic [$clog2(IMEM_DEPTH)-1:0] mem_addr,
  output logic                          mem_we,
  output logic [31:0]                   mem_wdata,
  input  logic [31:0]                   mem_rdata
);

  localparam int AW = $clog2(IMEM_DEPTH);
  localparam logic [3:0] MAX_BURST_C = 4'(MAX_BURST);

  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_FETCH} state_t;

  state_t          state_q, state_d;
  logic [3:0]      bcnt_q, bcnt_d;
  logic            f_gnt_d, l_gnt_d;
  logic [AW-1:0]   mem_addr_d;
  logic            mem_we_d;
  logic            f_bad, l_bad;

  logic            f_rvalid_q, l_rvalid_q;
  logic [31:0]     f_rdata_q, l_rdata_q;
  logic            f_err_q, l_err_q;

`ifdef IMEM_ARB_CHECK_EN
  assign f_bad = (f_addr[1:0] != 2'b00) || ({2'b00, f_addr[31:2]} >= 32'(IMEM_DEPTH));
  assign l_bad = (l_addr[1:0] != 2'b00) || ({2'b00, l_addr[31:2]} >= 32'(IMEM_DEPTH));
`else
  // Byte offset and upper address bits are don't-care: the word address wraps modulo the depth.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{f_addr[31:AW+2], f_addr[1:0], l_addr[31:AW+2], l_addr[1:0]};
  assign f_bad = 1'b0;
  assign l_bad = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      bcnt_q  <= 4'd0;
    end else begin
      state_q <= state_d;
      bcnt_q  <= bcnt_d;
    end
  end

  always_comb begin
    state_d    = ST_IDLE;
    bcnt_d     = 4'd0;
    f_gnt_d    = 1'b0;
    l_gnt_d    = 1'b0;
    mem_addr_d = '0;
    mem_we_d   = 1'b0;
    if (rst_n) begin
      if (l_req && (l_lock || !f_req || (bcnt_q < MAX_BURST_C))) begin
        l_gnt_d = 1'b1;
        state_d = ST_LOAD;
        // A loader grant following anything but a loader grant starts a fresh burst.
        if (state_q == ST_LOAD) begin
          bcnt_d = (bcnt_q == 4'hF) ? 4'hF : bcnt_q + 4'd1;
        end else begin
          bcnt_d = 4'd1;
        end
        if (!l_bad) begin
          mem_addr_d = l_addr[AW+1:2];
          mem_we_d   = l_we;
        end
      end else if (f_req && !l_lock) begin
        f_gnt_d = 1'b1;
        state_d = ST_FETCH;
        if (!f_bad) begin
          mem_addr_d = f_addr[AW+1:2];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      f_rvalid_q <= 1'b0;
      f_rdata_q  <= '0;
      f_err_q    <= 1'b0;
      l_rvalid_q <= 1'b0;
      l_rdata_q  <= '0;
      l_err_q    <= 1'b0;
    end else begin
      f_rvalid_q <= f_gnt_d;
      l_rvalid_q <= l_gnt_d;
      if (f_gnt_d) begin
        f_rdata_q <= f_bad ? 32'd0 : mem_rdata;
        f_err_q   <= f_bad;
      end
      if (l_gnt_d) begin
        l_rdata_q <= l_bad ? 32'd0 : (l_we ? l_wdata : mem_rdata);
        l_err_q   <= l_bad;
      end
    end
  end

  assign f_gnt     = f_gnt_d;
  assign l_gnt     = l_gnt_d;
  assign mem_addr  = mem_addr_d;
  assign mem_we    = mem_we_d;
  assign mem_wdata = l_wdata;

  // Responses are masked while reset is asserted so a response pending at reset never surfaces.
  assign f_rvalid  = f_rvalid_q & rst_n;
  assign l_rvalid  = l_rvalid_q & rst_n;
  assign f_rdata   = f_rdata_q;
  assign l_rdata   = l_rdata_q;
  assign f_err     = f_err_q;
  assign l_err     = l_err_q;

endmodule

// File: tb/tb_imem_arbiter.sv
// Self-checking bench for imem_arbiter: directed scenarios plus randomized traffic against a reference model.
module tb_imem_arbiter;
  localparam int DEPTH = 256;
  localparam int MAXB  = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        f_req, f_gnt, f_rvalid, f_err;
  logic [31:0] f_addr, f_rdata;
  logic        l_req, l_we, l_lock, l_gnt, l_rvalid, l_err;
  logic [31:0] l_addr, l_wdata, l_rdata;
  logic [7:0]  mem_addr;
  logic        mem_we;
  logic [31:0] mem_wdata, mem_rdata;

  logic [31:0] mem [DEPTH];
  logic [31:0] ref_mem [DEPTH];
  logic        pl_we;
  logic [7:0]  pl_idx;
  logic [31:0] pl_dat;

  int n_cmp = 0;
  int n_err = 0;

  imem_arbiter #(.IMEM_DEPTH(DEPTH), .MAX_BURST(MAXB)) dut (
    .clk(clk), .rst_n(rst_n),
    .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt), .f_rvalid(f_rvalid), .f_rdata(f_rdata), .f_err(f_err),
    .l_req(l_req), .l_we(l_we), .l_addr(l_addr), .l_wdata(l_wdata), .l_lock(l_lock),
    .l_gnt(l_gnt), .l_rvalid(l_rvalid), .l_rdata(l_rdata), .l_err(l_err),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Memory array: asynchronous read, write on the rising edge; preload port for setup.
  assign mem_rdata = mem[mem_addr];
  always @(posedge clk) begin
    if (pl_we) mem[pl_idx] <= pl_dat;
    if (mem_we) mem[mem_addr] <= mem_wdata;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, time=%0t required finish earlier", $time);
    $fatal(1, "watchdog");
  end

  task automatic idle_inputs();
    f_req = 0; f_addr = 0; l_req = 0; l_we = 0; l_addr = 0; l_wdata = 0; l_lock = 0;
  endtask

  task automatic preload(input int idx, input logic [31:0] d);
    @(negedge clk); pl_we = 1; pl_idx = idx[7:0]; pl_dat = d;
    @(negedge clk); pl_we = 0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 0; f_req = 1; l_req = 1; l_we = 1; l_addr = 32'h8; f_addr = 32'h4;
    #1;
    n_cmp++; if (f_gnt !== 1'b0) begin n_err++; $display("FAIL rst_f_gnt got=%0b exp=0", f_gnt); end
    n_cmp++; if (l_gnt !== 1'b0) begin n_err++; $display("FAIL rst_l_gnt got=%0b exp=0", l_gnt); end
    n_cmp++; if (mem_we !== 1'b0) begin n_err++; $display("FAIL rst_mem_we got=%0b exp=0", mem_we); end
    @(negedge clk);
    n_cmp++; if ({f_rvalid, f_err, l_rvalid, l_err} !== 4'b0) begin n_err++; $display("FAIL rst_flags got=%b exp=0000", {f_rvalid, f_err, l_rvalid, l_err}); end
    n_cmp++; if (f_rdata !== 32'd0) begin n_err++; $display("FAIL rst_f_rdata got=%h exp=0", f_rdata); end
    n_cmp++; if (l_rdata !== 32'd0) begin n_err++; $display("FAIL rst_l_rdata got=%h exp=0", l_rdata); end
    n_cmp++; if (mem_addr !== 8'd0) begin n_err++; $display("FAIL rst_mem_addr got=%h exp=0", mem_addr); end
    rst_n = 1; idle_inputs();
  endtask

  task automatic test_fetch_only();
    logic [31:0] w [3];
    w = '{32'h00000013, 32'h00100093, 32'h00200113};
    for (int i = 0; i < 3; i++) preload(i, w[i]);
    for (int i = 0; i <= 3; i++) begin
      @(negedge clk);
      if (i > 0) begin
        n_cmp++; if (f_rvalid !== 1'b1) begin n_err++; $display("FAIL fo_rvalid[%0d] got=%0b exp=1", i, f_rvalid); end
        n_cmp++; if (f_rdata !== w[i-1]) begin n_err++; $display("FAIL fo_rdata[%0d] got=%h exp=%h", i, f_rdata, w[i-1]); end
        n_cmp++; if (f_err !== 1'b0) begin n_err++; $display("FAIL fo_err[%0d] got=%0b exp=0", i, f_err); end
      end
      if (i < 3) begin
        f_req = 1; f_addr = 32'(i * 4);
        #1;
        n_cmp++; if (f_gnt !== 1'b1) begin n_err++; $display("FAIL fo_gnt[%0d] got=%0b exp=1", i, f_gnt); end
        n_cmp++; if (mem_addr !== 8'(i)) begin n_err++; $display("FAIL fo_mem_addr[%0d] got=%h exp=%h", i, mem_addr, 8'(i)); end
      end else begin
        f_req = 0;
      end
    end
  endtask

  task automatic test_write_then_fetch();
    @(negedge clk);
    l_req = 1; l_we = 1; l_addr = 32'h10; l_wdata = 32'hDEADBEEF;
    #1;
    n_cmp++; if (l_gnt !== 1'b1) begin n_err++; $display("FAIL wf_l_gnt got=%0b exp=1", l_gnt); end
    n_cmp++; if ({mem_we, mem_addr} !== {1'b1, 8'h04}) begin n_err++; $display("FAIL wf_mem got=%b/%h exp=1/04", mem_we, mem_addr); end
    n_cmp++; if (mem_wdata !== 32'hDEADBEEF) begin n_err++; $display("FAIL wf_mem_wdata got=%h exp=deadbeef", mem_wdata); end
    @(negedge clk);
    n_cmp++; if (l_rvalid !== 1'b1) begin n_err++; $display("FAIL wf_l_rvalid got=%0b exp=1", l_rvalid); end
    n_cmp++; if (l_rdata !== 32'hDEADBEEF) begin n_err++; $display("FAIL wf_l_rdata got=%h exp=deadbeef", l_rdata); end
    l_req = 0; l_we = 0; f_req = 1; f_addr = 32'h10;
    #1;
    n_cmp++; if (f_gnt !== 1'b1) begin n_err++; $display("FAIL wf_f_gnt got=%0b exp=1", f_gnt); end
    @(negedge clk);
    f_req = 0;
    n_cmp++; if (l_rvalid !== 1'b0) begin n_err++; $display("FAIL wf_l_rvalid_pulse got=%0b exp=0", l_rvalid); end
    n_cmp++; if (f_rvalid !== 1'b1) begin n_err++; $display("FAIL wf_f_rvalid got=%0b exp=1", f_rvalid); end
    n_cmp++; if (f_rdata !== 32'hDEADBEEF) begin n_err++; $display("FAIL wf_f_rdata got=%h exp=deadbeef", f_rdata); end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    l_req = 1; l_we = 1; l_addr = 32'h20; l_wdata = 32'hCAFEF00D;
    #1;
    n_cmp++; if (l_gnt !== 1'b1) begin n_err++; $display("FAIL rm_l_gnt got=%0b exp=1", l_gnt); end
    @(negedge clk);
    idle_inputs(); rst_n = 0;
    #1;
    n_cmp++; if (l_rvalid !== 1'b0) begin n_err++; $display("FAIL rm_l_rvalid got=%0b exp=0", l_rvalid); end
    @(negedge clk);
    n_cmp++; if ({f_rvalid, f_err, l_rvalid, l_err, f_gnt, l_gnt, mem_we} !== 7'b0) begin n_err++; $display("FAIL rm_flags got=%b exp=0000000", {f_rvalid, f_err, l_rvalid, l_err, f_gnt, l_gnt, mem_we}); end
    n_cmp++; if ({f_rdata, l_rdata} !== 64'd0) begin n_err++; $display("FAIL rm_rdata got=%h/%h exp=0/0", f_rdata, l_rdata); end
    rst_n = 1; f_req = 1; f_addr = 32'h20;
    #1;
    n_cmp++; if (f_gnt !== 1'b1) begin n_err++; $display("FAIL rm_f_gnt got=%0b exp=1", f_gnt); end
    @(negedge clk);
    f_req = 0;
    n_cmp++; if ({f_rvalid, f_rdata} !== {1'b1, 32'hCAFEF00D}) begin n_err++; $display("FAIL rm_f_rdata got=%0b/%h exp=1/cafef00d", f_rvalid, f_rdata); end
  endtask

  task automatic test_addr_check();
`ifdef IMEM_ARB_CHECK_EN
    logic [31:0] a [2];
    a = '{32'h402, 32'h400};
    for (int i = 0; i <= 2; i++) begin
      @(negedge clk);
      if (i > 0) begin
        n_cmp++; if ({f_rvalid, f_err, f_rdata} !== {2'b11, 32'd0}) begin n_err++; $display("FAIL ac_f_resp[%0d] got=%0b/%0b/%h exp=1/1/0", i, f_rvalid, f_err, f_rdata); end
      end
      if (i < 2) begin
        f_req = 1; f_addr = a[i];
        #1;
        n_cmp++; if ({f_gnt, mem_addr} !== {1'b1, 8'h00}) begin n_err++; $display("FAIL ac_f_gnt[%0d] got=%0b/%h exp=1/00", i, f_gnt, mem_addr); end
      end else begin
        f_req = 0;
      end
    end
    @(negedge clk);
    l_req = 1; l_we = 1; l_addr = 32'h400; l_wdata = 32'h12345678;
    #1;
    n_cmp++; if ({l_gnt, mem_we, mem_addr} !== {2'b10, 8'h00}) begin n_err++; $display("FAIL ac_l_write got=%0b/%0b/%h exp=1/0/00", l_gnt, mem_we, mem_addr); end
    @(negedge clk);
    idle_inputs();
    n_cmp++; if ({l_rvalid, l_err, l_rdata} !== {2'b11, 32'd0}) begin n_err++; $display("FAIL ac_l_resp got=%0b/%0b/%h exp=1/1/0", l_rvalid, l_err, l_rdata); end
`else
    logic [31:0] a [3];
    logic [31:0] e [3];
    logic [7:0]  wa [3];
    a  = '{32'h400, 32'h402, 32'h404};
    e  = '{32'h00000013, 32'h00000013, 32'h00100093};
    wa = '{8'h00, 8'h00, 8'h01};
    for (int i = 0; i <= 3; i++) begin
      @(negedge clk);
      if (i > 0) begin
        n_cmp++; if ({f_rvalid, f_err, f_rdata} !== {2'b10, e[i-1]}) begin n_err++; $display("FAIL wrap_resp[%0d] got=%0b/%0b/%h exp=1/0/%h", i, f_rvalid, f_err, f_rdata, e[i-1]); end
      end
      if (i < 3) begin
        f_req = 1; f_addr = a[i];
        #1;
        n_cmp++; if ({f_gnt, mem_addr} !== {1'b1, wa[i]}) begin n_err++; $display("FAIL wrap_gnt[%0d] got=%0b/%h exp=1/%h", i, f_gnt, mem_addr, wa[i]); end
      end else begin
        f_req = 0;
      end
    end
`endif
  endtask

  task automatic test_anti_starvation();
    logic exp_l;
    @(negedge clk); idle_inputs();
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      f_req = 1; f_addr = 32'h0; l_req = 1; l_we = 0; l_addr = 32'h4; l_lock = 0;
      exp_l = (i % (MAXB + 1)) != MAXB;
      #1;
      n_cmp++; if ({l_gnt, f_gnt} !== {exp_l, !exp_l}) begin n_err++; $display("FAIL burst[%0d] got l=%0b f=%0b exp l=%0b f=%0b", i, l_gnt, f_gnt, exp_l, !exp_l); end
    end
    @(negedge clk); idle_inputs();
  endtask

  task automatic test_lock();
    @(negedge clk); idle_inputs();
    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      f_req = 1; f_addr = 32'h0; l_req = 1; l_we = 0; l_addr = 32'h4; l_lock = (i < 12);
      #1;
      if (i < 12) begin
        n_cmp++; if ({l_gnt, f_gnt} !== 2'b10) begin n_err++; $display("FAIL lock[%0d] got l=%0b f=%0b exp l=1 f=0", i, l_gnt, f_gnt); end
      end else begin
        n_cmp++; if ({l_gnt, f_gnt} !== 2'b01) begin n_err++; $display("FAIL unlock got l=%0b f=%0b exp l=0 f=1", l_gnt, f_gnt); end
      end
    end
    @(negedge clk); idle_inputs();
  endtask

  function automatic logic [31:0] rand_addr();
`ifdef IMEM_ARB_CHECK_EN
    return {22'd0, 8'($urandom), 2'b00};
`else
    return $urandom;
`endif
  endfunction

  task automatic test_random();
    logic        fr, lr, lw, lk, exp_f, exp_l;
    logic [31:0] fa, la, ld;
    logic        ef_v, el_v, ef_known, el_known;
    logic [31:0] ef_d, el_d;
    int          streak;
    fr = 0; lr = 0; lw = 0; lk = 0; fa = 0; la = 0; ld = 0;
    ef_v = 0; el_v = 0; ef_known = 0; el_known = 0; ef_d = 0; el_d = 0; streak = 0;
    for (int i = 0; i < DEPTH; i++) begin
      logic [31:0] r;
      r = $urandom;
      ref_mem[i] = r;
      preload(i, r);
    end
    @(negedge clk); idle_inputs();
    for (int c = 0; c <= 400; c++) begin
      @(negedge clk);
      n_cmp++; if (f_rvalid !== ef_v) begin n_err++; $display("FAIL rnd_f_rvalid[%0d] got=%0b exp=%0b", c, f_rvalid, ef_v); end
      n_cmp++; if (l_rvalid !== el_v) begin n_err++; $display("FAIL rnd_l_rvalid[%0d] got=%0b exp=%0b", c, l_rvalid, el_v); end
      if (ef_known) begin
        n_cmp++; if (f_rdata !== ef_d) begin n_err++; $display("FAIL rnd_f_rdata[%0d] got=%h exp=%h", c, f_rdata, ef_d); end
      end
      if (el_known) begin
        n_cmp++; if (l_rdata !== el_d) begin n_err++; $display("FAIL rnd_l_rdata[%0d] got=%h exp=%h", c, l_rdata, el_d); end
      end
      if (ef_v || el_v) begin
        n_cmp++; if ((ef_v && f_err) || (el_v && l_err)) begin n_err++; $display("FAIL rnd_err[%0d] got f=%0b l=%0b exp 0", c, f_err, l_err); end
      end
      if (c == 400) break;
      if (!fr) begin fr = ($urandom_range(0, 3) != 0); fa = rand_addr(); end
      if (!lr) begin lr = ($urandom_range(0, 2) == 0); lw = 1'($urandom); la = rand_addr(); ld = $urandom; end
      lk = ($urandom_range(0, 7) == 0);
      f_req = fr; f_addr = fa; l_req = lr; l_we = lw; l_addr = la; l_wdata = ld; l_lock = lk;
      exp_l = lr && (lk || !fr || streak < MAXB);
      exp_f = !exp_l && fr && !lk;
      #1;
      n_cmp++; if ({l_gnt, f_gnt} !== {exp_l, exp_f}) begin n_err++; $display("FAIL rnd_gnt[%0d] got l=%0b f=%0b exp l=%0b f=%0b", c, l_gnt, f_gnt, exp_l, exp_f); end
      if (exp_l) begin
        n_cmp++; if ({mem_we, mem_addr} !== {lw, la[9:2]}) begin n_err++; $display("FAIL rnd_l_mem[%0d] got=%0b/%h exp=%0b/%h", c, mem_we, mem_addr, lw, la[9:2]); end
        if (lw) begin
          el_d = ld;
          ref_mem[la[9:2]] = ld;
        end else begin
          el_d = ref_mem[la[9:2]];
        end
        el_known = 1; lr = 0;
        streak = (streak < 15) ? streak + 1 : 15;
      end else if (exp_f) begin
        n_cmp++; if ({mem_we, mem_addr} !== {1'b0, fa[9:2]}) begin n_err++; $display("FAIL rnd_f_mem[%0d] got=%0b/%h exp=0/%h", c, mem_we, mem_addr, fa[9:2]); end
        ef_d = ref_mem[fa[9:2]];
        ef_known = 1; fr = 0; streak = 0;
      end else begin
        n_cmp++; if ({mem_we, mem_addr} !== 9'd0) begin n_err++; $display("FAIL rnd_idle_mem[%0d] got=%0b/%h exp=0/00", c, mem_we, mem_addr); end
        streak = 0;
      end
      ef_v = exp_f; el_v = exp_l;
    end
    idle_inputs();
  endtask

  initial begin
    rst_n = 0; pl_we = 0; pl_idx = 0; pl_dat = 0;
    idle_inputs();
    test_reset();
    test_fetch_only();
    test_write_then_fetch();
    test_reset_mid();
    test_addr_check();
    test_anti_starvation();
    test_lock();
    test_random();
    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/imem_arbiter.md
# imem_arbiter

Shares the single port of the instruction memory between the core fetch stage and a loader/debug master. The loader can rewrite program words, for example during watchdog-triggered reload. The arbiter sits between the PC/fetch logic and the memory array. It decides a grant each cycle, drives the memory address and write strobes, and returns registered read data and write acknowledgements to the winning requester. A burst limiter stops the loader from starving fetch, unless the loader explicitly locks the port.

## Interface
- IMEM_DEPTH, 256, memory depth in 32-bit words; AW = $clog2(IMEM_DEPTH).
- MAX_BURST, 4, maximum consecutive loader grants while fetch waits and lock is low; range 1..15.

- clk  in  1  system clock, all logic on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- f_req  in  1  fetch read request.
- f_addr  in  32  fetch byte address (PC).
- f_gnt  out  1  fetch granted this cycle (combinational).
- f_rvalid  out  1  fetch read data valid, one-cycle pulse.
- f_rdata  out  32  fetch read data.
- f_err  out  1  fetch access error, qualified by f_rvalid.
- l_req  in  1  loader request.
- l_we  in  1  loader write (1) / read (0).
- l_addr  in  32  loader byte address.
- l_wdata  in  32  loader write data.
- l_lock  in  1  level; while high, fetch is never granted.
- l_gnt  out  1  loader granted this cycle (combinational).
- l_rvalid  out  1  loader response valid (read data or write ack), one-cycle pulse.
- l_rdata  out  32  loader read data; on a write ack, echoes the written data.
- l_err  out  1  loader access error, qualified by l_rvalid.
- mem_addr  out  AW  word address to the memory array.
- mem_we  out  1  memory write enable.
- mem_wdata  out  32  memory write data.
- mem_rdata  in  32  asynchronous read data from the array.

## Operation
- FSM states: IDLE (no grant last cycle), LOAD (loader granted last cycle), FETCH (fetch granted last cycle).
- 4-bit burst counter bcnt counts consecutive loader grants.
- Grant decision, evaluated with rst_n high:
  - l_req && (l_lock || !f_req || bcnt < MAX_BURST) → l_gnt.
  - Otherwise f_req && !l_lock → f_gnt.
  - Otherwise no grant.
- At most one grant per cycle.
- Transitions:
  - Loader grant → LOAD, bcnt += 1, saturating at 15.
  - Fetch grant → FETCH, bcnt = 0.
  - No grant → IDLE, bcnt = 0.
- Memory drive in the grant cycle:
  - mem_addr = granted addr[AW+1:2].
  - mem_we = l_gnt & l_we.
  - mem_wdata = l_wdata.
  - With no grant: mem_addr = 0 and mem_we = 0.
- Response path:
  - The rvalid of the winner is registered high in the cycle after its grant.
  - rdata is registered from mem_rdata; for a loader write, it is registered from l_wdata.
  - The non-winner's rdata holds its previous value.
- A write and a read to the same address in consecutive cycles are legal; the read returns the new word.

## Timing
- Grant is the same cycle as the request; response latency is exactly 1 cycle; sustained throughput is 1 access per cycle.
- Requesters hold req/addr/we/wdata stable until they see gnt high. A request withdrawn before grant is dropped.
- l_lock takes effect in the same cycle it rises. It does not clear bcnt.
- Reset (rst_n low at a rising edge): all outputs 0, state IDLE, bcnt = 0.
  - While rst_n is low, f_gnt, l_gnt and mem_we are forced 0 combinationally.
  - A response due in the cycle after a reset edge is dropped.
- f_req and l_req rising together from IDLE: loader wins.

## Configuration
- IMEM_ARB_CHECK_EN defined:
  - An access with addr[1:0] != 0 or addr[31:2] >= IMEM_DEPTH is still granted.
  - The access sees mem_we = 0 and mem_addr = 0.
  - It returns rvalid with err = 1 and rdata = 0 one cycle later.
  - It counts toward bcnt like any loader grant.
- IMEM_ARB_CHECK_EN undefined:
  - f_err and l_err are tied 0.
  - addr[1:0] is ignored and the word address is truncated to AW bits (wraps modulo IMEM_DEPTH).

## Test plan
- Fetch only: f_addr = 0,4,8 back-to-back with memory preloaded with 0x00000013, 0x00100093, 0x00200113 → f_gnt high each cycle; f_rvalid one cycle later with those words in order; f_err = 0.
- Loader write then fetch: l_we = 1, l_addr = 0x10, l_wdata = 0xDEADBEEF; next cycle f_addr = 0x10 → l_rvalid with l_rdata = 0xDEADBEEF; then f_rdata = 0xDEADBEEF.
- Anti-starvation: MAX_BURST = 4, f_req and l_req held high for 12 cycles, l_lock = 0 → grant pattern L,L,L,L,F,L,L,L,L,F,L,L.
- Lock: same stimulus with l_lock = 1 → 12 consecutive loader grants, f_gnt never high; drop l_lock after cycle 12 → fetch granted the next cycle (bcnt ≥ 4).
- Reset mid-operation: rst_n low in the cycle after a loader write grant to 0x20 → l_rvalid stays 0; all outputs 0; the write in the grant cycle has already committed; after release, fetch of 0x20 returns the written data.
- IMEM_ARB_CHECK_EN defined, IMEM_DEPTH = 256: f_addr = 0x402 and then 0x400 → both give f_err = 1, f_rdata = 0. A loader write to 0x400 leaves mem_we = 0 and returns l_err = 1. Without the macro, f_addr = 0x400 returns word 0.
